// File: rtl/multdiv_pkg.sv
// multdiv_pkg: FSM encoding, iteration count and operand constants shared by the multiply/divide unit.
package multdiv_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0]  ITER_COUNT = 6'd32;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: operand, start and result signals between the execute stage and the multiply/divide unit.
interface multdiv_if;

    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/multdiv_counter.sv
// multdiv_counter: 6-bit loadable down-counter that stops at zero and flags it.
module multdiv_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [5:0] cnt;

    assign zero = cnt == 6'd0;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= 6'd0;
        else if (load)
            cnt <= load_val;
        else if (en && !zero)
            cnt <= cnt - 6'd1;
    end

endmodule

// File: rtl/multdiv.sv
// multdiv: sequential signed 32-bit shift-add multiplier and restoring divider, 33-cycle latency.
// Define MULTDIV_DIV_EN to build the divider; without it ctrl_DIV returns an exception one cycle later.
module multdiv
    import multdiv_pkg::*;
(
    input logic      clock,
    input logic      reset,
    multdiv_if.slave bus
);

`ifdef MULTDIV_DIV_EN
    localparam logic [5:0] DIV_ITERS = ITER_COUNT;
`else
    localparam logic [5:0] DIV_ITERS = 6'd0;
`endif

    logic [1:0]  state;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic [31:0] result;
    logic        neg;
    logic        err;
    logic        zero_div;
    logic        exc;
    logic        rdy;
    logic        start;
    logic        iterating;
    logic        cnt_zero;
    logic [32:0] mul_sum;
    logic [63:0] product;
    logic [31:0] final_res;
    logic        final_exc;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign iterating = state == MUL || state == DIV;

    // Both operations run on magnitudes; neg restores the sign at the end.
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    assign product = neg ? -acc : acc;

`ifdef MULTDIV_DIV_EN
    logic [31:0] divisor;
    logic [32:0] diff;
    logic [63:0] div_next;
    logic [31:0] quotient;

    // Remainder stays below the divisor (at most 2^31), so acc[63] is always clear here.
    assign diff      = {1'b0, acc[62:31]} - {1'b0, divisor};
    assign div_next  = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    assign quotient  = neg ? -acc[31:0] : acc[31:0];
    assign final_res = zero_div ? 32'd0 : (state == DIV ? quotient : product[31:0]);
`else
    assign final_res = zero_div ? 32'd0 : product[31:0];
`endif

    assign final_exc = err | (state == MUL && product[63:32] != {32{product[31]}});

    multdiv_counter u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (start),
        .load_val (bus.ctrl_MULT ? ITER_COUNT : DIV_ITERS),
        .en       (iterating),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            neg      <= 1'b0;
            err      <= 1'b0;
            zero_div <= 1'b0;
            result   <= '0;
            exc      <= 1'b0;
            rdy      <= 1'b0;
`ifdef MULTDIV_DIV_EN
            divisor  <= '0;
`endif
        end else begin
            rdy <= 1'b0;
            if (bus.ctrl_MULT) begin
                state    <= MUL;
                mcand    <= magnitude(bus.data_operandA);
                acc      <= {32'd0, magnitude(bus.data_operandB)};
                neg      <= bus.data_operandA[31] ^ bus.data_operandB[31];
                err      <= 1'b0;
                zero_div <= 1'b0;
            end else if (bus.ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
                state    <= DIV;
                divisor  <= magnitude(bus.data_operandB);
                acc      <= {32'd0, magnitude(bus.data_operandA)};
                neg      <= bus.data_operandA[31] ^ bus.data_operandB[31];
                zero_div <= bus.data_operandB == 32'd0;
                err      <= bus.data_operandB == 32'd0 ||
                            (bus.data_operandA == INT_MIN && bus.data_operandB == NEG_ONE);
`else
                // Zero-length MUL pass with a cleared accumulator: completes next cycle as an error.
                state    <= MUL;
                acc      <= '0;
                neg      <= 1'b0;
                zero_div <= 1'b1;
                err      <= 1'b1;
`endif
            end else if (iterating && cnt_zero) begin
                state  <= DONE;
                rdy    <= 1'b1;
                result <= final_res;
                exc    <= final_exc;
            end else if (state == MUL) begin
                acc <= {mul_sum, acc[31:1]};
`ifdef MULTDIV_DIV_EN
            end else if (state == DIV) begin
                acc <= div_next;
`endif
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = rdy;

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: randomized and directed checks of multdiv against an arithmetic reference model.
module tb_multdiv;

`ifdef MULTDIV_DIV_EN
    localparam int DIV_LAT = 33;
`else
    localparam int DIV_LAT = 1;
`endif
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    multdiv_if bus ();

    multdiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {exception, result} from plain signed arithmetic
    function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        if (m) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            lo = p[31:0];
            return {p != longint'($signed(lo)), lo};
        end
`ifdef MULTDIV_DIV_EN
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == MIN32 && b == 32'hFFFF_FFFF) return {1'b1, MIN32};
        return {1'b0, 32'($signed(a) / $signed(b))};
`else
        return {1'b1, 32'd0};
`endif
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0, 1: v = $urandom;
            2: begin
                v = $urandom_range(0, 300);
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            3: v = 32'd0;
            default: v = $urandom_range(0, 1) == 1 ? MIN32 : 32'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    // Called 1 time unit after an edge; the next edge is the start edge (cycle 0).
    task automatic launch(input logic m, input logic [31:0] a, input logic [31:0] b, input logic both);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT = m | both;
        bus.ctrl_DIV  = !m | both;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic expect_done(input string tag, input logic m, input logic [31:0] a,
                               input logic [31:0] b, input bit tail);
        logic [32:0] e;
        int n;
        e = model(m, a, b);
        n = 0;
        while (bus.data_resultRDY !== 1'b1 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(m ? 33 : DIV_LAT));
        check({tag, "_res"}, 64'(bus.data_result), 64'(e[31:0]));
        check({tag, "_exc"}, 64'(bus.data_exception), 64'(e[32]));
        if (tail) begin
            @(posedge clock);
            #1;
            check({tag, "_pulse"}, 64'(bus.data_resultRDY), 64'd0);
            check({tag, "_hold"}, 64'({bus.data_exception, bus.data_result}), 64'(e));
        end
    endtask

    logic        dm [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] da [9] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFD, 32'h8000_0000,
                            32'hFFFF_FFEC, 32'd100, 32'h8000_0000, 32'd100, 32'h8000_0000};
    logic [31:0] db [9] = '{32'd6, 32'h0001_0000, 32'd4, 32'hFFFF_FFFF,
                            32'd3, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};

    initial begin
        logic [32:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rm;
        int          pulses;
        int          at;
        logic [32:0] seen;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_res", 64'(bus.data_result), 64'd0);
        check("rst_exc", 64'(bus.data_exception), 64'd0);

        for (int i = 0; i < 9; i++) begin
            launch(dm[i], da[i], db[i], 1'b0);
            expect_done($sformatf("dir%0d", i), dm[i], da[i], db[i], 1'b1);
        end

        launch(1'b1, 32'hFFFF_FFF9, 32'd9, 1'b1);
        expect_done("both", 1'b1, 32'hFFFF_FFF9, 32'd9, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = rnd_operand();
            rb = rnd_operand();
            launch(rm, ra, rb, 1'b0);
            expect_done($sformatf("rnd%0d", i), rm, ra, rb, 1'($urandom_range(0, 1)));
        end

        launch(1'b1, 32'd123, 32'hFFFF_FFD3, 1'b0);
        expect_done("dn_first", 1'b1, 32'd123, 32'hFFFF_FFD3, 1'b0);
        launch(1'b0, 32'd1000, 32'hFFFF_FFF9, 1'b0);
        expect_done("dn_second", 1'b0, 32'd1000, 32'hFFFF_FFF9, 1'b1);

        launch(1'b1, 32'd3, 32'd4, 1'b0);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        launch(1'b0, 32'd100, 32'd7, 1'b0);
        e = model(1'b0, 32'd100, 32'd7);
        pulses = 0;
        at = -1;
        seen = '0;
        for (int i = 1; i <= 60; i++) begin
            if (bus.data_resultRDY === 1'b1 && i > 1 && at < 0) at = -2;
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                at = i;
                seen = {bus.data_exception, bus.data_result};
            end
        end
        check("rs_pulses", 64'(pulses), 64'd1);
        check("rs_cycle", 64'(at), 64'(DIV_LAT));
        check("rs_value", 64'(seen), 64'(e));

        launch(1'b1, 32'd5, 32'd5, 1'b0);
        repeat (14) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mr_res", 64'(bus.data_result), 64'd0);
        check("mr_exc", 64'(bus.data_exception), 64'd0);
        pulses = 0;
        for (int i = 16; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY !== 1'b0) pulses++;
        end
        check("mr_pulses", 64'(pulses), 64'd0);
        check("mr_final", 64'({bus.data_exception, bus.data_result}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv.md
# multdiv

Sequential 32-bit signed multiply/divide unit that sits beside the combinational ALU (and32, add32, shifters) in the CPU execute stage. The pipeline starts an operation with a one-cycle control pulse. The unit answers with a one-cycle ready pulse, a result and an exception flag. The pipeline stalls between the two pulses. Multiply uses 32-iteration shift-add; divide uses 32-iteration restoring division.

## Interface
- No parameters; width fixed at 32.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- data_operandA  in  32  multiplicand / dividend; sampled only on a start cycle.
- data_operandB  in  32  multiplier / divisor; sampled only on a start cycle.
- ctrl_MULT  in  1  one-cycle start pulse for multiply.
- ctrl_DIV  in  1  one-cycle start pulse for divide.
- data_result  out  32  registered result; held until the next completion.
- data_exception  out  1  registered error flag; held with data_result.
- data_resultRDY  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Start cycle: any clock edge with ctrl_MULT or ctrl_DIV high. If both are high, ctrl_MULT wins.
- On a start cycle:
  - latch operands;
  - load the iteration counter with 32;
  - go to MUL or DIV.
- A start accepted in any state, including MUL, DIV or DONE, aborts the operation in flight and restarts with the new operands. The aborted operation never produces a ready pulse.
- Multiply:
  - signed two's complement, full 64-bit product formed internally;
  - data_result = product[31:0];
  - data_exception = 1 when product[63:32] is not the sign extension of product[31];
  - 0x80000000 × 0xFFFFFFFF flags overflow.
- Divide:
  - operate on operand magnitudes, then fix the sign;
  - quotient truncates toward zero; remainder is discarded.
  - Divisor 0: data_result = 0, data_exception = 1.
  - 0x80000000 / 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
- DONE:
  - data_resultRDY = 1 for exactly one cycle;
  - data_result and data_exception update on entry;
  - then go to IDLE.
- Reset values: state IDLE, data_result 0, data_exception 0, data_resultRDY 0, counter 0.
- Reset mid-operation discards all progress. No ready pulse follows.

## Timing
- Start edge = cycle 0.
- Iterations run on edges 1..32.
- data_resultRDY is high during cycle 33, with data_result and data_exception valid in the same cycle. Latency is 33 cycles for both operations, including divide-by-zero and the overflow cases.
- data_result and data_exception stay stable from cycle 33 until the next completion, or until reset.
- A restart at cycle k of a running operation moves the ready pulse to cycle k+33.
- A start in the DONE cycle itself is legal: the ready pulse still fires, and the new operation completes 33 cycles later.
- Pipeline contract: operands need to be valid only on the start cycle.

## Configuration
- MULTDIV_DIV_EN defined: full divide path, as specified above.
- MULTDIV_DIV_EN undefined:
  - divider datapath and the DIV state are compiled out;
  - ctrl_DIV still aborts any operation in flight;
  - ctrl_DIV produces data_result = 0 and data_exception = 1, with data_resultRDY in cycle 1;
  - multiply behaviour is unchanged.

## Structure
- Package multdiv_pkg holds:
  - state encoding constants (IDLE, MUL, DIV, DONE);
  - ITER_COUNT = 32;
  - INT_MIN = 32'h80000000;
  - NEG_ONE = 32'hFFFFFFFF.
- Sub-module multdiv_counter: 6-bit loadable down-counter.
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Used for the iteration count.
- Datapath registers (multiplicand, 64-bit accumulator/shift register, divisor, remainder, sign bits) live in the top module.

## Test plan
- MULT 7 × 6 → data_result 0x0000002A, data_exception 0, data_resultRDY exactly once, at cycle 33.
- MULT 0x00010000 × 0x00010000 → data_result 0x00000000, data_exception 1. Also MULT 0xFFFFFFFD × 4 → 0xFFFFFFF4, data_exception 0.
- DIV 0xFFFFFFEC / 3 (−20/3) → 0xFFFFFFFA (−6), data_exception 0. DIV 100 / 0 → 0x00000000, data_exception 1, at cycle 33.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, data_exception 1. With MULTDIV_DIV_EN undefined, DIV 100 / 7 → 0, data_exception 1, data_resultRDY at cycle 1.
- Restart: MULT 3 × 4 at cycle 0, then DIV 100 / 7 at cycle 10 → a single ready pulse, at cycle 43, with data_result 14; no pulse at cycle 33.
- Reset at cycle 15 of MULT 5 × 5 → no ready pulse through cycle 60; data_result 0 and data_exception 0 from the reset edge onward.
